rng_arbiter: RTL and testbench

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 112 +++++++++++
 tb/tb_rng_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - two-requester round-robin arbiter serving LFSR random bytes
//
// Purpose: owns one 8-bit LFSR. After reset or a seed load the LFSR is
// warmed up for WARMUP shifts, then each served request advances it by
// STEPS shifts and hands the resulting byte to the granted requester.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   seed_we  load seed into the LFSR, aborting any in-flight request
//   seed     seed value
//   req      level request per requester, held until its gnt bit is seen
//   gnt      one-hot, one-cycle grant pulse; rdata valid in the same cycle
//   rdata    random byte, held between grants
//   busy     high in every state except READY
module rng_arbiter #(
  parameter int WARMUP = 16,
  parameter int STEPS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_we,
  input  logic [7:0] seed,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [7:0] rdata,
  output logic       busy
);

  localparam int MAXC = (WARMUP > STEPS) ? WARMUP : STEPS;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] WARM_CNT = CW'(WARMUP);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEPS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_WARM  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_GRANT = 2'd3;

  // With no warm-up the block is immediately ready after reset / reseed.
  localparam logic [1:0] S_INIT = (WARMUP == 0) ? S_READY : S_WARM;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_next;
  logic [7:0]    rdata_q;
  logic          sel;      // requester being served
  logic          last;     // requester granted most recently
  logic          win;
  logic          grant_fire;

  // The extra (lfsr == 0) term kicks the register out of the all-zero lock-up.
  assign lfsr_next = {lfsr[4] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0] ^ (lfsr == 8'h00),
                      lfsr[7:1]};

  // Round robin: a lone request wins outright; on contention the requester
  // that was not granted last wins. last resets to 1 so requester 0 is favoured.
  assign win = (req == 2'b11) ? ~last : req[1];

  // A seed load in the GRANT cycle cancels the grant, so gnt and the rdata
  // bypass are qualified by seed_we directly.
  assign grant_fire = (state == S_GRANT) && !seed_we;

  assign gnt   = grant_fire ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign rdata = grant_fire ? lfsr : rdata_q;
  assign busy  = (state != S_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      cnt     <= WARM_CNT;
      lfsr    <= 8'h01;
      rdata_q <= 8'h00;
      sel     <= 1'b0;
      last    <= 1'b1;
    end else if (seed_we) begin
      lfsr  <= seed;
      cnt   <= WARM_CNT;
      state <= S_INIT;
    end else begin
      case (state)
        S_WARM: begin
          lfsr <= lfsr_next;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_READY;
        end
        S_READY: begin
          if (req != 2'b00) begin
            sel   <= win;
            cnt   <= STEP_CNT;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          lfsr <= lfsr_next;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_GRANT;
        end
        S_GRANT: begin
          rdata_q <= lfsr;
          last    <= sel;
          state   <= S_READY;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - scoreboard bench for rng_arbiter
module tb_rng_arbiter;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;

  // u0: WARMUP=0 STEPS=4, u1: defaults, u2: WARMUP=0 STEPS=1
  logic       rst0, rst1;
  logic       seed_we0, seed_we1, seed_we2;
  logic [7:0] seed0, seed1, seed2;
  logic [1:0] req0, req1, req2;
  logic [1:0] gnt0, gnt1, gnt2;
  logic [7:0] rdata0, rdata1, rdata2;
  logic       busy0, busy1, busy2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  rng_arbiter #(.WARMUP(0), .STEPS(4)) u0 (
    .clk(clk), .rst(rst0), .seed_we(seed_we0), .seed(seed0), .req(req0),
    .gnt(gnt0), .rdata(rdata0), .busy(busy0));

  rng_arbiter u1 (
    .clk(clk), .rst(rst1), .seed_we(seed_we1), .seed(seed1), .req(req1),
    .gnt(gnt1), .rdata(rdata1), .busy(busy1));

  rng_arbiter #(.WARMUP(0), .STEPS(1)) u2 (
    .clk(clk), .rst(rst0), .seed_we(seed_we2), .seed(seed2), .req(req2),
    .gnt(gnt2), .rdata(rdata2), .busy(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: every grant pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst0 && gnt0 != 2'b00) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL u0_unexpected_gnt got gnt=%b rdata=%h cyc=%0d required no grant", gnt0, rdata0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (gnt0 !== e0.g || rdata0 !== e0.d || cyc != e0.c) begin
          errors++;
          $display("FAIL u0_grant got gnt=%b rdata=%h cyc=%0d required gnt=%b rdata=%h cyc=%0d",
                   gnt0, rdata0, cyc, e0.g, e0.d, e0.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && gnt1 != 2'b00) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_gnt got gnt=%b rdata=%h cyc=%0d required no grant", gnt1, rdata1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (gnt1 !== e1.g || rdata1 !== e1.d || cyc != e1.c) begin
          errors++;
          $display("FAIL u1_grant got gnt=%b rdata=%h cyc=%0d required gnt=%b rdata=%h cyc=%0d",
                   gnt1, rdata1, cyc, e1.g, e1.d, e1.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst0 && gnt2 != 2'b00) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL u2_unexpected_gnt got gnt=%b rdata=%h cyc=%0d required no grant", gnt2, rdata2, cyc);
      end else begin
        e2 = q2.pop_front();
        if (gnt2 !== e2.g || rdata2 !== e2.d || cyc != e2.c) begin
          errors++;
          $display("FAIL u2_grant got gnt=%b rdata=%h cyc=%0d required gnt=%b rdata=%h cyc=%0d",
                   gnt2, rdata2, cyc, e2.g, e2.d, e2.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int k;
  int nbusy;

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    seed_we0 = 1'b0; seed_we1 = 1'b0; seed_we2 = 1'b0;
    seed0 = 8'h00; seed1 = 8'h00; seed2 = 8'h00;
    req0 = 2'b00; req1 = 2'b00; req2 = 2'b00;

    // Reset state
    tick(2);
    chk("rst_busy_w0",  {31'd0, busy0}, 32'd0);
    chk("rst_busy_w16", {31'd0, busy1}, 32'd1);
    chk("rst_rdata_u0", {24'd0, rdata0}, 32'h00);
    chk("rst_rdata_u1", {24'd0, rdata1}, 32'h00);
    chk("rst_gnt_all",  {26'd0, gnt0, gnt1, gnt2}, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Default warm-up: busy for 16 cycles after release, outputs quiet
    nbusy = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy1 && gnt1 == 2'b00 && rdata1 == 8'h00) nbusy++;
      tick(1);
    end
    chk("warm_busy_cycles", nbusy, 32'd16);
    chk("warm_done_busy",   {31'd0, busy1}, 32'd0);

    // Default params: 16 warm + 8 step shifts from 01 -> 03, latency STEPS+1
    req1 = 2'b01;
    q1.push_back('{2'b01, 8'h03, cyc + 9});
    tick(10);
    req1 = 2'b00;

    // Reset mid-STEP drops the operation; rdata clears at once
    req1 = 2'b10;
    tick(3);
    rst1 = 1'b1;
    req1 = 2'b00;
    #1;
    chk("midstep_rst_rdata", {24'd0, rdata1}, 32'h00);
    chk("midstep_rst_busy",  {31'd0, busy1}, 32'd1);
    tick(1);
    rst1 = 1'b0;

    // u0: seed 01, then two grants to requester 0
    seed_we0 = 1'b1; seed0 = 8'h01;
    tick(1);
    seed_we0 = 1'b0;
    req0 = 2'b01;
    q0.push_back('{2'b01, 8'h10, cyc + 5});
    tick(6);
    req0 = 2'b00;
    req0 = 2'b01;
    q0.push_back('{2'b01, 8'h71, cyc + 5});
    tick(6);
    req0 = 2'b00;

    // Deassert during STEP still grants: 71 -> 38,1C,8E,47
    req0 = 2'b10;
    q0.push_back('{2'b10, 8'h47, cyc + 5});
    tick(1);
    req0 = 2'b00;
    tick(5);

    // Reseed during STEP aborts; held req re-served from new seed A5 -> 2A
    req0 = 2'b01;
    tick(2);
    seed_we0 = 1'b1; seed0 = 8'hA5;
    tick(1);
    seed_we0 = 1'b0;
    q0.push_back('{2'b01, 8'h2A, cyc + 5});
    tick(6);
    req0 = 2'b00;

    // Reseed coincident with GRANT suppresses gnt, rdata held
    req0 = 2'b01;
    tick(5);
    seed_we0 = 1'b1; seed0 = 8'h01;
    #1;
    chk("grant_reseed_gnt",   {30'd0, gnt0}, 32'd0);
    chk("grant_reseed_rdata", {24'd0, rdata0}, 32'h2A);
    tick(1);
    seed_we0 = 1'b0;
    q0.push_back('{2'b01, 8'h10, cyc + 5});
    tick(6);
    req0 = 2'b00;

    // u2: all-zero seed recovers to 80
    seed_we2 = 1'b1; seed2 = 8'h00;
    tick(1);
    seed_we2 = 1'b0;
    req2 = 2'b10;
    q2.push_back('{2'b10, 8'h80, cyc + 2});
    tick(3);
    req2 = 2'b00;

    // Both requesting: alternate starting with requester 0 (1 was last)
    req2 = 2'b11;
    q2.push_back('{2'b01, 8'h40, cyc + 2});
    q2.push_back('{2'b10, 8'h20, cyc + 5});
    q2.push_back('{2'b01, 8'h10, cyc + 8});
    q2.push_back('{2'b10, 8'h88, cyc + 11});
    tick(12);
    req2 = 2'b00;

    // Every expected grant must have appeared
    tick(12);
    chk("u0_missing_grants", q0.size(), 32'd0);
    chk("u1_missing_grants", q1.size(), 32'd0);
    chk("u2_missing_grants", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
